mem_access_unit: RTL

Memory-stage access unit sitting on the output side of the EX/MEM pipeline register and driving the MEM/WB pipeline register. It decodes load/store intent from the EX/MEM control fields, runs a valid/ready transaction against the data memory port, aligns and extends load data, and stalls the upstream pipeline until the access completes. Non-memory instructions pass through with one register stage of latency.

---
 rtl/mem_access_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs a valid/ready data-memory transaction and feeds the MEM/WB register.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and retire flagged misaligned_out.
module mem_access_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    localparam int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] instruction_in,
    input  logic [XLEN-1:0] ALU_result_in,
    input  logic [XLEN-1:0] regOut_B_in,
    input  logic            RegWEn_in,
    input  logic            MemRW_in,
    input  logic [1:0]      WBsel_in,
    output logic            stall,
    output logic            dmem_req_valid,
    output logic            dmem_req_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_req_ready,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] instruction_out,
    output logic [XLEN-1:0] ALU_result_out,
    output logic [XLEN-1:0] mem_data_out,
    output logic            RegWEn_out,
    output logic [1:0]      WBsel_out,
    output logic            misaligned_out
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP, S_DONE} state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      wstrb;
        logic            we;
        logic [2:0]      funct3;
        logic [1:0]      lane;
    } req_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] mem_data;
        logic            regwen;
        logic [1:0]      wbsel;
        logic            misaligned;
    } mewb_t;

    state_e          state_q, state_d;
    req_t            req_q, req_d;
    mewb_t           mewb_q, mewb_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] ld_data_q, ld_data_d;

    logic [2:0]      funct3_c;
    logic            is_load_c, is_store_c, memop_c, trap_c;
    logic [1:0]      lane_c;
    logic [XLEN-1:0] wdata_c;
    logic [3:0]      wstrb_c;
    mewb_t           pass_c, bubble_c;

    // Select the addressed byte/halfword of the returned word and extend it.
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] funct3,
                                                     input logic [1:0] lane,
                                                     input logic [XLEN-1:0] word);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Decode and size-masked lane, write data and strobes.
    always_comb begin
        funct3_c   = instruction_in[14:12];
        is_store_c = MemRW_in;
        is_load_c  = RegWEn_in && (WBsel_in == 2'b00) && !MemRW_in;
        memop_c    = is_load_c || is_store_c;
        lane_c     = 2'b00;
        wdata_c    = regOut_B_in;
        wstrb_c    = 4'hF;
        case (funct3_c[1:0])
            2'b00: begin
                lane_c  = ALU_result_in[1:0];
                wdata_c = {4{regOut_B_in[7:0]}};
                wstrb_c = 4'b0001 << lane_c;
            end
            2'b01: begin
                lane_c  = {ALU_result_in[1], 1'b0};
                wdata_c = {2{regOut_B_in[15:0]}};
                wstrb_c = 4'b0011 << lane_c;
            end
            default: ;
        endcase
`ifdef MISALIGN_TRAP_EN
        // Masking dropped address bits means the access was not naturally aligned.
        trap_c = memop_c && (lane_c != ALU_result_in[1:0]);
`else
        trap_c = 1'b0;
`endif
    end

    always_comb begin
        pass_c = '{pc: pc_in, instr: instruction_in, alu: ALU_result_in, mem_data: '0,
                   regwen: RegWEn_in && !trap_c, wbsel: WBsel_in, misaligned: trap_c};
        bubble_c            = pass_c;
        bubble_c.instr      = NOP_INSTR;
        bubble_c.regwen     = 1'b0;
        bubble_c.misaligned = 1'b0;
    end

    // Next-state and MEM/WB payload; bubble is the default while stalled.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        req_valid_d = 1'b0;
        ld_data_d   = ld_data_q;
        mewb_d      = bubble_c;
        stall       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (memop_c && !trap_c) begin
                    stall       = 1'b1;
                    state_d     = S_REQ;
                    req_valid_d = 1'b1;
                    req_d       = '{addr: {ALU_result_in[XLEN-1:2], 2'b00}, wdata: wdata_c,
                                    wstrb: wstrb_c, we: is_store_c, funct3: funct3_c,
                                    lane: lane_c};
                end else begin
                    mewb_d = pass_c;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (dmem_req_ready) begin
                    state_d = req_q.we ? S_DONE : S_WAIT_RSP;
                end else begin
                    req_valid_d = 1'b1;
                end
            end
            S_WAIT_RSP: begin
                stall = 1'b1;
                if (dmem_rsp_valid) begin
                    ld_data_d = load_extend(req_q.funct3, req_q.lane, dmem_rdata);
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d         = S_IDLE;
                mewb_d          = pass_c;
                mewb_d.mem_data = req_q.we ? '0 : ld_data_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            req_valid_q <= 1'b0;
            ld_data_q   <= '0;
            mewb_q      <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            req_valid_q <= req_valid_d;
            ld_data_q   <= ld_data_d;
            mewb_q      <= mewb_d;
        end
    end

    assign dmem_req_valid  = req_valid_q;
    assign dmem_req_we     = req_q.we;
    assign dmem_addr       = req_q.addr;
    assign dmem_wdata      = req_q.wdata;
    assign dmem_wstrb      = req_q.wstrb;
    assign pc_out          = mewb_q.pc;
    assign instruction_out = mewb_q.instr;
    assign ALU_result_out  = mewb_q.alu;
    assign mem_data_out    = mewb_q.mem_data;
    assign RegWEn_out      = mewb_q.regwen;
    assign WBsel_out       = mewb_q.wbsel;
    assign misaligned_out  = mewb_q.misaligned;

endmodule
